// File: rtl/wb_gpio_pkg.sv
// Shared definitions for the Wishbone GPIO controller.
// Holds the register word offsets (wb_adr_i[4:2]), the maximum pin count,
// the register-field reset defaults and the byte-enable expansion helper.
package wb_gpio_pkg;

    localparam int GPIO_MAX_WIDTH = 32;

    // Register select values (word offset = byte address >> 2)
    localparam logic [2:0] REG_DATA_IN  = 3'd0;
    localparam logic [2:0] REG_DATA_OUT = 3'd1;
    localparam logic [2:0] REG_DIR      = 3'd2;
    localparam logic [2:0] REG_SET      = 3'd3;
    localparam logic [2:0] REG_CLR      = 3'd4;
    localparam logic [2:0] REG_IRQ_EN   = 3'd5;
    localparam logic [2:0] REG_IRQ_POL  = 3'd6;
    localparam logic [2:0] REG_IRQ_STAT = 3'd7;

    // Register-field reset defaults
    localparam logic [31:0] OUT_RESET_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] DIR_RESET_DEFAULT = 32'h0000_0000;

    // Expand the four byte enables into a 32-bit write mask
    function automatic logic [31:0] byte_mask(input logic [3:0] sel);
        return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
    endfunction

endpackage

// File: rtl/gpio_in_filter.sv
// Input conditioning for the GPIO pads.
// Each pin passes a 2-flop synchroniser, then either goes straight through
// (DEBOUNCE_DIV = 0) or through a shared-tick debounce filter. The filtered
// value is compared with its previous-cycle copy to produce edge pulses.
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   pins        asynchronous pad inputs
//   filtered    conditioned input level
//   rise, fall  one-cycle edge pulses of 'filtered'
module gpio_in_filter
    import wb_gpio_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int DEBOUNCE_DIV = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] pins,
    output logic [WIDTH-1:0] filtered,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    logic [WIDTH-1:0] sync1_r;
    logic [WIDTH-1:0] sync2_r;
    logic [WIDTH-1:0] filt_s;
    logic [WIDTH-1:0] prev_r;

    // Two-flop synchroniser for the asynchronous pad inputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= {WIDTH{1'b0}};
            sync2_r <= {WIDTH{1'b0}};
        end else begin
            sync1_r <= pins;
            sync2_r <= sync1_r;
        end
    end

    generate
        if (DEBOUNCE_DIV == 0) begin : g_bypass
            assign filt_s = sync2_r;
        end else begin : g_debounce
            localparam int CNT_W = (DEBOUNCE_DIV > 1) ? $clog2(DEBOUNCE_DIV) : 1;
            localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_DIV - 1);

            logic [CNT_W-1:0] cnt_r;
            logic             tick_s;
            logic [WIDTH-1:0] sample_r;
            logic [WIDTH-1:0] deb_r;
            logic [WIDTH-1:0] agree_s;

            assign tick_s  = (cnt_r == CNT_MAX);
            // A bit may only move when this tick's sample matches the last one
            assign agree_s = ~(sync2_r ^ sample_r);

            // Shared prescaler: counts 0..DEBOUNCE_DIV-1 and ticks on wrap
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_r <= {CNT_W{1'b0}};
                end else if (tick_s) begin
                    cnt_r <= {CNT_W{1'b0}};
                end else begin
                    cnt_r <= cnt_r + CNT_W'(1);
                end
            end

            // Tick sampling and two-sample agreement filter
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sample_r <= {WIDTH{1'b0}};
                    deb_r    <= {WIDTH{1'b0}};
                end else if (tick_s) begin
                    sample_r <= sync2_r;
                    deb_r    <= (deb_r & ~agree_s) | (sync2_r & agree_s);
                end else begin
                    sample_r <= sample_r;
                    deb_r    <= deb_r;
                end
            end

            assign filt_s = deb_r;
        end
    endgenerate

    // Previous filtered level for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_r <= {WIDTH{1'b0}};
        end else begin
            prev_r <= filt_s;
        end
    end

    assign filtered = filt_s;
    assign rise     = filt_s & ~prev_r;
    assign fall     = ~filt_s & prev_r;

endmodule

// File: rtl/wb_gpio_irq.sv
// Wishbone GPIO controller with per-pin direction, atomic set/clear,
// conditioned inputs and per-pin edge interrupts with a combined level IRQ.
// Ports:
//   wb_clk_i, wb_rst_n_i        clock, asynchronous active-low reset
//   wb_adr_i/dat_i/sel_i/we_i   Wishbone request (byte address, bits [4:2] used)
//   wb_cyc_i, wb_stb_i          Wishbone cycle / strobe
//   wb_dat_o, wb_ack_o          read data (0 when not acking), one-cycle ack
//   gpio_i, gpio_o, gpio_dir_o  pad inputs, output values, output enables
//   irq_o                       level interrupt, |(IRQ_STAT & IRQ_EN)
module wb_gpio_irq
    import wb_gpio_pkg::*;
#(
    parameter int          GPIO_WIDTH   = 8,
    parameter int          DEBOUNCE_DIV = 0,
    parameter logic [31:0] OUT_RESET    = OUT_RESET_DEFAULT,
    parameter logic [31:0] DIR_RESET    = DIR_RESET_DEFAULT
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_n_i,
    input  logic [4:0]            wb_adr_i,
    input  logic [31:0]           wb_dat_i,
    input  logic [3:0]            wb_sel_i,
    input  logic                  wb_we_i,
    input  logic                  wb_cyc_i,
    input  logic                  wb_stb_i,
    output logic [31:0]           wb_dat_o,
    output logic                  wb_ack_o,
    input  logic [GPIO_WIDTH-1:0] gpio_i,
    output logic [GPIO_WIDTH-1:0] gpio_o,
    output logic [GPIO_WIDTH-1:0] gpio_dir_o,
    output logic                  irq_o
);

    localparam logic [GPIO_WIDTH-1:0] OUT_RST = OUT_RESET[GPIO_WIDTH-1:0];
    localparam logic [GPIO_WIDTH-1:0] DIR_RST = DIR_RESET[GPIO_WIDTH-1:0];

    logic                      ack_r;
    logic [31:0]               dat_r;
    logic                      irq_r;
    logic [GPIO_WIDTH-1:0]     out_r, dir_r, en_r, pol_r, stat_r;
    logic [GPIO_WIDTH-1:0]     out_nxt_s, dir_nxt_s, en_nxt_s, pol_nxt_s, stat_nxt_s;
    logic [GPIO_WIDTH-1:0]     clr_s, event_s, wmask_s, wdat_s;
    logic [GPIO_WIDTH-1:0]     filt_s, rise_s, fall_s;
    logic [GPIO_MAX_WIDTH-1:0] mask_s, rdata_s;
    logic [2:0]                reg_sel_s;
    logic                      req_s, wr_s, rd_s;
    logic                      unused_s;

    gpio_in_filter #(
        .WIDTH        (GPIO_WIDTH),
        .DEBOUNCE_DIV (DEBOUNCE_DIV)
    ) u_in_filter (
        .clk      (wb_clk_i),
        .rst_n    (wb_rst_n_i),
        .pins     (gpio_i),
        .filtered (filt_s),
        .rise     (rise_s),
        .fall     (fall_s)
    );

    // A new request is accepted only while no ack is outstanding, so a held
    // strobe is acknowledged every other cycle.
    assign req_s     = wb_cyc_i & wb_stb_i & ~ack_r;
    assign wr_s      = req_s & wb_we_i;
    assign rd_s      = req_s & ~wb_we_i;
    assign reg_sel_s = wb_adr_i[4:2];
    assign mask_s    = byte_mask(wb_sel_i);
    assign wmask_s   = mask_s[GPIO_WIDTH-1:0];
    assign wdat_s    = wb_dat_i[GPIO_WIDTH-1:0] & wmask_s;
    assign event_s   = (rise_s & pol_r) | (fall_s & ~pol_r);

    // Byte address bits and write data above the pin count carry no state
    assign unused_s  = ^{wb_adr_i[1:0], wb_dat_i, mask_s};

    // Register next-state: byte-masked writes, SET/CLR and IRQ_STAT W1C
    always_comb begin
        out_nxt_s = out_r;
        dir_nxt_s = dir_r;
        en_nxt_s  = en_r;
        pol_nxt_s = pol_r;
        clr_s     = {GPIO_WIDTH{1'b0}};
        if (wr_s) begin
            case (reg_sel_s)
                REG_DATA_OUT: out_nxt_s = (out_r & ~wmask_s) | wdat_s;
                REG_DIR:      dir_nxt_s = (dir_r & ~wmask_s) | wdat_s;
                REG_SET:      out_nxt_s = out_r | wdat_s;
                REG_CLR:      out_nxt_s = out_r & ~wdat_s;
                REG_IRQ_EN:   en_nxt_s  = (en_r & ~wmask_s) | wdat_s;
                REG_IRQ_POL:  pol_nxt_s = (pol_r & ~wmask_s) | wdat_s;
                REG_IRQ_STAT: clr_s     = wdat_s;
                default:      clr_s     = {GPIO_WIDTH{1'b0}};
            endcase
        end else begin
            clr_s = {GPIO_WIDTH{1'b0}};
        end
        // A new edge wins over a simultaneous clear of the same bit
        stat_nxt_s = (stat_r & ~clr_s) | event_s;
    end

    // Read multiplexer; write-only and unimplemented bits read as zero
    always_comb begin
        rdata_s = 32'h0000_0000;
        case (reg_sel_s)
            REG_DATA_IN:  rdata_s = 32'(filt_s);
            REG_DATA_OUT: rdata_s = 32'(out_r);
            REG_DIR:      rdata_s = 32'(dir_r);
            REG_IRQ_EN:   rdata_s = 32'(en_r);
            REG_IRQ_POL:  rdata_s = 32'(pol_r);
            REG_IRQ_STAT: rdata_s = 32'(stat_r);
            default:      rdata_s = 32'h0000_0000;
        endcase
    end

    // Bus response, control registers and the registered interrupt
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            ack_r  <= 1'b0;
            dat_r  <= 32'h0000_0000;
            out_r  <= OUT_RST;
            dir_r  <= DIR_RST;
            en_r   <= {GPIO_WIDTH{1'b0}};
            pol_r  <= {GPIO_WIDTH{1'b0}};
            stat_r <= {GPIO_WIDTH{1'b0}};
            irq_r  <= 1'b0;
        end else begin
            ack_r  <= req_s;
            dat_r  <= rd_s ? rdata_s : 32'h0000_0000;
            out_r  <= out_nxt_s;
            dir_r  <= dir_nxt_s;
            en_r   <= en_nxt_s;
            pol_r  <= pol_nxt_s;
            stat_r <= stat_nxt_s;
            irq_r  <= |(stat_r & en_r);
        end
    end

    assign wb_ack_o   = ack_r;
    assign wb_dat_o   = dat_r;
    assign gpio_o     = out_r;
    assign gpio_dir_o = dir_r;
    assign irq_o      = irq_r;

endmodule

// File: tb/tb_wb_gpio_irq.sv
// Self-checking bench for wb_gpio_irq: a 16-bit bypass instance (a) and an
// 8-bit debounced instance (b) share one bus. Read expectations come from a
// register-level reference model and are queued; a monitor compares them
// against each acknowledged transfer.
module tb_wb_gpio_irq;

    localparam logic [31:0] OUT_RST_A = 32'hFFFF_5A3C;
    localparam logic [31:0] DIR_RST_A = 32'h0000_00F0;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  adr = 5'd0;
    logic [31:0] wdat = 32'h0;
    logic [3:0]  sel = 4'h0;
    logic        we = 1'b0;
    logic        cyc_a = 1'b0, stb_a = 1'b0, cyc_b = 1'b0, stb_b = 1'b0;
    logic [31:0] dat_a, dat_b;
    logic        ack_a, ack_b, irq_a, irq_b;
    logic [15:0] pins_a = 16'h0, gpo_a, dir_a;
    logic [7:0]  pins_b = 8'h0, gpo_b, dir_b;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          dut;
        logic [4:0]  adr;
        logic [31:0] exp;
    } exp_t;
    exp_t sb[$];

    // Reference model, index 0 = instance a, 1 = instance b
    logic [31:0] m_out[2], m_dir[2], m_en[2], m_pol[2], m_stat[2], m_pins[2], m_wmask[2];
    logic        prev_ack_a = 1'b0, prev_ack_b = 1'b0;

    always #5 clk = ~clk;

    wb_gpio_irq #(.GPIO_WIDTH(16), .DEBOUNCE_DIV(0), .OUT_RESET(OUT_RST_A), .DIR_RESET(DIR_RST_A)) dut_a (
        .wb_clk_i(clk), .wb_rst_n_i(rst_n), .wb_adr_i(adr), .wb_dat_i(wdat), .wb_sel_i(sel),
        .wb_we_i(we), .wb_cyc_i(cyc_a), .wb_stb_i(stb_a), .wb_dat_o(dat_a), .wb_ack_o(ack_a),
        .gpio_i(pins_a), .gpio_o(gpo_a), .gpio_dir_o(dir_a), .irq_o(irq_a));

    wb_gpio_irq #(.GPIO_WIDTH(8), .DEBOUNCE_DIV(16), .OUT_RESET(32'h0), .DIR_RESET(32'h0)) dut_b (
        .wb_clk_i(clk), .wb_rst_n_i(rst_n), .wb_adr_i(adr), .wb_dat_i(wdat), .wb_sel_i(sel),
        .wb_we_i(we), .wb_cyc_i(cyc_b), .wb_stb_i(stb_b), .wb_dat_o(dat_b), .wb_ack_o(ack_b),
        .gpio_i(pins_b), .gpio_o(gpo_b), .gpio_dir_o(dir_b), .irq_o(irq_b));

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_out[0] = OUT_RST_A & 32'h0000_FFFF;  m_dir[0] = DIR_RST_A & 32'h0000_FFFF;
        m_out[1] = 32'h0;                      m_dir[1] = 32'h0;
        m_wmask[0] = 32'h0000_FFFF;            m_wmask[1] = 32'h0000_00FF;
        for (int d = 0; d < 2; d++) begin
            m_en[d] = 32'h0; m_pol[d] = 32'h0; m_stat[d] = 32'h0;
        end
    endtask

    function automatic logic [31:0] m_read(input int d, input logic [4:0] a);
        case (a[4:2])
            3'd0:    return m_pins[d];
            3'd1:    return m_out[d];
            3'd2:    return m_dir[d];
            3'd5:    return m_en[d];
            3'd6:    return m_pol[d];
            3'd7:    return m_stat[d];
            default: return 32'h0;
        endcase
    endfunction

    task automatic m_write(input int d, input logic [4:0] a, input logic [31:0] v, input logic [3:0] s);
        logic [31:0] m, dv;
        m  = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}} & m_wmask[d];
        dv = v & m;
        case (a[4:2])
            3'd1: m_out[d]  = (m_out[d] & ~m) | dv;
            3'd2: m_dir[d]  = (m_dir[d] & ~m) | dv;
            3'd3: m_out[d]  = m_out[d] | dv;
            3'd4: m_out[d]  = m_out[d] & ~dv;
            3'd5: m_en[d]   = (m_en[d] & ~m) | dv;
            3'd6: m_pol[d]  = (m_pol[d] & ~m) | dv;
            3'd7: m_stat[d] = m_stat[d] & ~dv;
            default: m = 32'h0;
        endcase
    endtask

    // One Wishbone transfer; the expected read data is queued for the monitor
    task automatic xfer(input int d, input logic w, input logic [4:0] a,
                        input logic [31:0] v, input logic [3:0] s);
        exp_t e;
        bit   got;
        e.dut = d; e.adr = a; e.exp = w ? 32'h0 : m_read(d, a);
        sb.push_back(e);
        @(posedge clk); #1;
        adr = a; wdat = v; sel = s; we = w;
        if (d == 0) begin cyc_a = 1'b1; stb_a = 1'b1; end
        else begin cyc_b = 1'b1; stb_b = 1'b1; end
        got = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            @(posedge clk); #1;
            if ((d == 0) ? ack_a : ack_b) got = 1'b1;
        end
        cyc_a = 1'b0; stb_a = 1'b0; cyc_b = 1'b0; stb_b = 1'b0;
        if (!got) begin
            checks++; errors++;
            $display("FAIL ack_timeout dut%0d adr=%h: got no ack, required one within 8 cycles", d, a);
            void'(sb.pop_back());
        end
        if (w) m_write(d, a, v, s);
    endtask

    // Change pad inputs; edges selected by the modelled polarity set status
    task automatic set_pins(input int d, input logic [31:0] v, input int settle);
        logic [31:0] nv, old;
        nv  = v & m_wmask[d];
        old = m_pins[d];
        m_stat[d] = m_stat[d] | (m_pol[d] & nv & ~old) | (~m_pol[d] & old & ~nv);
        m_pins[d] = nv;
        @(posedge clk); #1;
        if (d == 0) pins_a = nv[15:0];
        else pins_b = nv[7:0];
        repeat (settle) @(posedge clk);
        #1;
    endtask

    task automatic check_outs(input int d);
        repeat (2) @(posedge clk);
        #1;
        if (d == 0) begin
            check("gpio_o_a", 32'(gpo_a), m_out[0]);
            check("gpio_dir_a", 32'(dir_a), m_dir[0]);
            check("irq_a", 32'(irq_a), 32'(|(m_stat[0] & m_en[0])));
        end else begin
            check("gpio_o_b", 32'(gpo_b), m_out[1]);
            check("gpio_dir_b", 32'(dir_b), m_dir[1]);
            check("irq_b", 32'(irq_b), 32'(|(m_stat[1] & m_en[1])));
        end
    endtask

    task automatic mon_port(input int d, input logic ack, input logic [31:0] dat, input logic prev);
        exp_t e;
        if (ack) begin
            checks++;
            if (prev) begin
                errors++;
                $display("FAIL ack_width dut%0d: ack high two cycles running, required one", d);
            end
            if (sb.size() == 0 || sb[0].dut != d) begin
                checks++; errors++;
                $display("FAIL unexpected_ack dut%0d: ack with no transfer pending", d);
            end else begin
                e = sb.pop_front();
                check($sformatf("rdata dut%0d adr=%h", d, e.adr), dat, e.exp);
            end
        end else begin
            check($sformatf("idle_dat dut%0d", d), dat, 32'h0);
        end
    endtask

    // Monitor: compare every acknowledged transfer against the queue
    always @(negedge clk) begin
        if (rst_n) begin
            mon_port(0, ack_a, dat_a, prev_ack_a);
            mon_port(1, ack_b, dat_b, prev_ack_b);
            prev_ack_a = ack_a;
            prev_ack_b = ack_b;
        end else begin
            prev_ack_a = 1'b0;
            prev_ack_b = 1'b0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        model_reset();
        m_pins[0] = 32'h0; m_pins[1] = 32'h0;

        // Reset values while reset is held
        #12;
        check("rst_ack_a", 32'(ack_a), 32'h0);
        check("rst_gpio_o_a", 32'(gpo_a), 32'h0000_5A3C);
        check("rst_dir_a", 32'(dir_a), 32'h0000_00F0);
        check("rst_irq_a", 32'(irq_a), 32'h0);
        @(negedge clk); rst_n = 1'b1;

        // Read every register of both instances
        for (int i = 0; i < 8; i++) xfer(0, 1'b0, 5'(i * 4), 32'h0, 4'hF);
        for (int i = 0; i < 8; i++) xfer(1, 1'b0, 5'(i * 4), 32'h0, 4'hF);

        // DATA_OUT, SET, CLR sequence
        xfer(0, 1'b1, 5'h04, 32'h0000_00A5, 4'hF); check_outs(0);
        check("step_a5", 32'(gpo_a), 32'h0000_00A5);
        xfer(0, 1'b1, 5'h0C, 32'h0000_000F, 4'hF); check_outs(0);
        check("step_af", 32'(gpo_a), 32'h0000_00AF);
        xfer(0, 1'b1, 5'h10, 32'h0000_0081, 4'hF); check_outs(0);
        check("step_2e", 32'(gpo_a), 32'h0000_002E);
        // Byte-0-only write on the 16-bit instance, high bits ignored
        xfer(0, 1'b1, 5'h04, 32'hFFFF_BEEF, 4'b0001); check_outs(0);
        check("sel_byte0", 32'(gpo_a), 32'h0000_00EF);
        xfer(0, 1'b1, 5'h08, 32'hFFFF_FFFF, 4'hF); check_outs(0);
        xfer(0, 1'b0, 5'h08, 32'h0, 4'hF);

        // Held strobe: an ack every other cycle
        for (int i = 0; i < 3; i++) begin
            exp_t e;
            e.dut = 0; e.adr = 5'h08; e.exp = m_dir[0];
            sb.push_back(e);
        end
        @(posedge clk); #1;
        adr = 5'h08; we = 1'b0; sel = 4'hF; cyc_a = 1'b1; stb_a = 1'b1;
        n = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (ack_a) n++;
        end
        cyc_a = 1'b0; stb_a = 1'b0;
        check("held_strobe_acks", 32'(n), 32'd3);

        // Rising edge on pin 3: status one cycle after filter, irq one after that
        set_pins(0, 32'h0, 6);
        xfer(0, 1'b1, 5'h14, 32'h0000_0008, 4'hF);
        xfer(0, 1'b1, 5'h18, 32'h0000_0008, 4'hF);
        xfer(0, 1'b1, 5'h1C, 32'hFFFF_FFFF, 4'hF);
        @(posedge clk); #1;
        pins_a = 16'h0008; m_pins[0] = 32'h8; m_stat[0] = m_stat[0] | 32'h8;
        repeat (3) @(posedge clk);
        #1 check("irq_not_yet", 32'(irq_a), 32'h0);
        @(posedge clk);
        #1 check("irq_latency", 32'(irq_a), 32'h1);
        xfer(0, 1'b0, 5'h00, 32'h0, 4'hF);
        xfer(0, 1'b0, 5'h1C, 32'h0, 4'hF);
        xfer(0, 1'b1, 5'h1C, 32'h0000_0008, 4'hF); check_outs(0);

        // Edge on pin 2 in the same cycle as its W1C: the set wins
        xfer(0, 1'b1, 5'h18, 32'h0000_0004, 4'hF);
        set_pins(0, 32'h4, 6);
        set_pins(0, 32'h0, 6);
        @(posedge clk); #1;
        pins_a = 16'h0004;
        @(posedge clk); #1;
        xfer(0, 1'b1, 5'h1C, 32'h0000_0004, 4'hF);
        m_pins[0] = 32'h4; m_stat[0] = m_stat[0] | 32'h4;
        xfer(0, 1'b0, 5'h1C, 32'h0, 4'hF);

        // Randomized traffic and pin activity on the bypass instance
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                set_pins(0, $urandom, 6);
                check("irq_after_pins", 32'(irq_a), 32'(|(m_stat[0] & m_en[0])));
            end else begin
                xfer(0, 1'($urandom), 5'($urandom), $urandom, 4'($urandom));
                check_outs(0);
            end
        end
        for (int i = 0; i < 8; i++) xfer(0, 1'b0, 5'(i * 4), 32'h0, 4'hF);

        // Debounced instance: short pulse filtered, long levels pass
        xfer(1, 1'b1, 5'h14, 32'h0000_00FF, 4'hF);
        xfer(1, 1'b1, 5'h18, 32'h0000_0001, 4'hF);
        @(posedge clk); #1 pins_b = 8'h01;
        repeat (10) @(posedge clk);
        #1 pins_b = 8'h00;
        repeat (60) @(posedge clk);
        xfer(1, 1'b0, 5'h00, 32'h0, 4'hF);
        xfer(1, 1'b0, 5'h1C, 32'h0, 4'hF);
        check_outs(1);
        set_pins(1, 32'h1, 40);
        xfer(1, 1'b0, 5'h00, 32'h0, 4'hF);
        xfer(1, 1'b0, 5'h1C, 32'h0, 4'hF);
        check_outs(1);
        xfer(1, 1'b1, 5'h18, 32'h0, 4'hF);
        xfer(1, 1'b1, 5'h1C, 32'h0000_00FF, 4'hF);
        check_outs(1);
        set_pins(1, 32'h0, 40);
        xfer(1, 1'b0, 5'h00, 32'h0, 4'hF);
        xfer(1, 1'b0, 5'h1C, 32'h0, 4'hF);
        check_outs(1);

        // Reset in the middle of a held transfer
        xfer(0, 1'b1, 5'h04, 32'h0000_1234, 4'hF);
        @(posedge clk); #1;
        adr = 5'h08; we = 1'b0; sel = 4'hF; cyc_a = 1'b1; stb_a = 1'b1;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_ack", 32'(ack_a), 32'h0);
        check("rst_mid_dat", dat_a, 32'h0);
        check("rst_mid_gpio_o", 32'(gpo_a), 32'h0000_5A3C);
        check("rst_mid_dir", 32'(dir_a), 32'h0000_00F0);
        check("rst_mid_irq_b", 32'(irq_b), 32'h0);
        cyc_a = 1'b0; stb_a = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        model_reset();
        repeat (5) @(posedge clk);
        #1 check("post_rst_ack", 32'(ack_a), 32'h0);
        for (int i = 0; i < 8; i++) xfer(0, 1'b0, 5'(i * 4), 32'h0, 4'hF);
        check_outs(0);
        check_outs(1);

        repeat (4) @(posedge clk);
        if (sb.size() != 0) begin
            checks++; errors++;
            $display("FAIL sb_drain: %0d transfers still pending, required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
